// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } sram_state_e;

  localparam int unsigned SRAM_DW           = 16;
  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

endpackage : sram_pkg

// File: rtl/sram_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit async SRAM as two
// half-word phases; ready drops while an access is in flight.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  sram_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        read_data_q, read_data_d;

  logic               req;
  logic               cnt_last;
  logic [31:0]        word;
  logic [SRAM_AW-1:0] addr_lo;
  logic [SRAM_AW-1:0] addr_hi;

  // A simultaneous rd_en/wr_en is a write; rd_en only contributes to req.
  assign req      = rd_en | wr_en;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign word     = (address - 32'(BASE_ADDR)) >> 2;
  assign addr_lo  = SRAM_AW'({word, 1'b0});
  assign addr_hi  = SRAM_AW'({word, 1'b1});

  assign ready     = ~req | (state_q == ST_DONE);
  assign read_data = read_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
    end
  end

  // Strobe drops on the last cycle of each write phase so address/data hold past WE rise.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req) state_d = ST_LOW;
      end

      ST_LOW: begin
        sram_addr = addr_lo;
        if (wr_en) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = write_data[15:0];
          sram_we_n   = cnt_last;
        end
        if (cnt_last) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          if (!wr_en) read_data_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HIGH: begin
        sram_addr = addr_hi;
        if (wr_en) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = write_data[31:16];
          sram_we_n   = cnt_last;
        end
        if (cnt_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          if (!wr_en) read_data_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule : sram_controller

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM plus a word-level
// reference model of memory contents and the last load result.
module tb_sram_controller;

  localparam int unsigned W    = 2;
  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;

  logic [15:0]   mem [0:(1<<AW)-1];
  logic [15:0]   ref_mem [int unsigned];
  logic [31:0]   ref_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  // Asynchronous SRAM: latches whatever is on the bus while WE is low.
  always @(negedge clk) if (!sram_we_n) mem[sram_addr] = sram_dq_out;
  assign sram_dq_in = mem[sram_addr];

  function automatic logic [AW-1:0] half_addr(input logic [31:0] a, input int hi);
    longint unsigned off, idx;
    off = (64'(a) + 64'h1_0000_0000 - 64'(BASE)) % 64'h1_0000_0000;
    idx = (off / 4) * 2 + 64'(hi);
    return AW'(idx % (64'd1 << AW));
  endfunction

  function automatic logic [15:0] ref_get(input logic [AW-1:0] ha);
    if (ref_mem.exists(32'(ha))) return ref_mem[32'(ha)];
    return 16'h0000;
  endfunction

  task automatic preload(input logic [AW-1:0] ha, input logic [15:0] v);
    mem[ha] = v;
    ref_mem[32'(ha)] = v;
  endtask

  // One access from request to DONE, checking every bus cycle on the way.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input string tag);
    int k;
    bit done;
    int ph;
    int pos;
    logic [AW-1:0] lo, hi, ea;
    logic [15:0] ed;
    lo = half_addr(a, 0);
    hi = half_addr(a, 1);
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    k = 0; done = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      if (ready) done = 1;
      else begin
        k++;
        if (k >= 2 && k <= 1 + 2 * int'(W)) begin
          ph  = (k - 2) / int'(W);
          pos = (k - 2) % int'(W);
          ea  = (ph == 1) ? hi : lo;
          n_cmp++;
          if (sram_addr !== ea) begin
            n_bad++; $display("FAIL %s sram_addr cyc%0d got %h exp %h", tag, k, sram_addr, ea);
          end
          if (wr) begin
            ed = (ph == 1) ? d[31:16] : d[15:0];
            n_cmp++;
            if (sram_dq_oe !== 1'b1 || sram_dq_out !== ed ||
                sram_we_n !== ((pos == int'(W) - 1) ? 1'b1 : 1'b0)) begin
              n_bad++; $display("FAIL %s wr_bus cyc%0d got oe=%b dq=%h we_n=%b exp dq=%h", tag, k,
                                sram_dq_oe, sram_dq_out, sram_we_n, ed);
            end
          end else begin
            n_cmp++;
            if (sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1) begin
              n_bad++; $display("FAIL %s rd_bus cyc%0d got oe=%b we_n=%b exp 0/1", tag, k,
                                sram_dq_oe, sram_we_n);
            end
          end
        end
      end
    end
    n_cmp++;
    if (!done || k != 1 + 2 * int'(W)) begin
      n_bad++; $display("FAIL %s ready_low got %0d (done=%0d) exp %0d", tag, k, done, 1 + 2 * W);
    end
    if (wr) begin
      ref_mem[32'(lo)] = d[15:0];
      ref_mem[32'(hi)] = d[31:16];
      n_cmp++;
      if (mem[lo] !== ref_get(lo) || mem[hi] !== ref_get(hi)) begin
        n_bad++; $display("FAIL %s sram_content got %h_%h exp %h_%h", tag, mem[hi], mem[lo],
                          ref_get(hi), ref_get(lo));
      end
    end else begin
      ref_rd = {ref_get(hi), ref_get(lo)};
    end
    n_cmp++;
    if (read_data !== ref_rd) begin
      n_bad++; $display("FAIL %s read_data got %h exp %h", tag, read_data, ref_rd);
    end
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; wr_en = 0; rd_en = 0; address = '0; write_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 ||
        sram_addr !== '0 || sram_dq_out !== '0 || read_data !== 32'h0) begin
      n_bad++; $display("FAIL reset got rdy=%b we_n=%b oe=%b a=%h dq=%h rd=%h exp 1/1/0/0/0/0",
                        ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data);
    end
    ref_rd = 32'h0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
        n_bad++; $display("FAIL idle cyc%0d got rdy=%b we_n=%b oe=%b exp 1/1/0", i, ready,
                          sram_we_n, sram_dq_oe);
      end
    end
  endtask

  task automatic test_write();
    do_access(1, 0, 32'd1024, 32'hDEADBEEF, "write");
    n_cmp++;
    if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin
      n_bad++; $display("FAIL write_const got %h %h exp beef dead", mem[0], mem[1]);
    end
  endtask

  task automatic test_read();
    do_access(0, 1, 32'd1024, 32'h0, "read0");
    n_cmp++;
    if (read_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL read0_const got %h exp deadbeef", read_data);
    end
    preload(4, 16'h1234);
    preload(5, 16'h5678);
    do_access(0, 1, 32'd1032, 32'h0, "read4");
    n_cmp++;
    if (read_data !== 32'h56781234) begin
      n_bad++; $display("FAIL read4_const got %h exp 56781234", read_data);
    end
  endtask

  task automatic test_both();
    do_access(1, 1, 32'd1028, 32'h0000CAFE, "both");
    n_cmp++;
    if (mem[2] !== 16'hCAFE || mem[3] !== 16'h0000 || read_data !== 32'h56781234) begin
      n_bad++; $display("FAIL both_const got %h %h rd=%h exp cafe 0000 56781234", mem[2], mem[3],
                        read_data);
    end
  endtask

  task automatic test_reset_mid_write();
    preload(6, 16'h0);
    preload(7, 16'h0);
    @(posedge clk); #1;
    wr_en = 1; address = 32'd1036; write_data = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);   // IDLE detect, LOW 0, LOW 1
    rst = 1; wr_en = 0;
    @(negedge clk);
    n_cmp++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== '0 ||
        read_data !== 32'h0 || ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid got we_n=%b oe=%b a=%h rd=%h rdy=%b exp 1/0/0/0/1",
                        sram_we_n, sram_dq_oe, sram_addr, read_data, ready);
    end
    @(posedge clk); #1;
    rst = 0;
    repeat (W * 3) @(negedge clk);
    n_cmp++;
    if (mem[7] !== 16'h0000) begin
      n_bad++; $display("FAIL rst_mid_hi got %h exp 0000", mem[7]);
    end
    ref_mem[6] = mem[6];
    ref_rd = 32'h0;
  endtask

  task automatic test_back_to_back();
    int dones[$];
    logic [31:0] exp;
    preload(half_addr(32'd1040, 0), 16'hA5A5);
    preload(half_addr(32'd1040, 1), 16'h3C3C);
    exp = {ref_get(half_addr(32'd1040, 1)), ref_get(half_addr(32'd1040, 0))};
    @(posedge clk); #1;
    rd_en = 1; address = 32'd1040;
    for (int i = 0; i < 2 * (2 * int'(W) + 2); i++) begin
      @(negedge clk);
      if (ready) begin
        dones.push_back(i);
        n_cmp++;
        if (read_data !== exp) begin
          n_bad++; $display("FAIL b2b read_data@%0d got %h exp %h", i, read_data, exp);
        end
      end
    end
    @(posedge clk); #1;
    rd_en = 0;
    n_cmp++;
    if (dones.size() != 2 || (dones.size() == 2 && dones[1] - dones[0] != 2 * int'(W) + 2)) begin
      n_bad++; $display("FAIL b2b done_count got %0d exp 2 (period %0d)", dones.size(), 2 * W + 2);
    end
    ref_rd = exp;
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 32'(BASE) - 32'(4 * $urandom_range(1, 4));
      else a = 32'(BASE) + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      do_access(op != 0, op != 1, a, $urandom, "rand");
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_both();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sram_controller
